// File: rtl/dmem_responder.sv
// Purpose : single-port data-memory responder behind a req/gnt/rvalid core bus.
// Latency : req->gnt WAIT_STATES cycles (same cycle when 0), gnt->rvalid 1 cycle.
// Backpr. : core holds data_req_i until data_gnt_o; one transaction in flight,
//           so a new grant comes no earlier than the cycle after the response.
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_i         synchronous active-high reset (memory contents are kept)
//   data_req_i    request, held by the core until granted
//   data_gnt_o    request accepted this cycle (address/we/be/wdata sampled now)
//   data_rvalid_o one-cycle response pulse, the cycle after the grant
//   data_we_i     1 = write, 0 = read
//   data_be_i     byte enables for writes (bit n -> bits 8n+7:8n)
//   data_addr_i   byte address; bits [1:0] ignored
//   data_wdata_i  write data
//   data_rdata_o  read data, non-zero only with a successful read response
//   data_err_o    bus error, valid with data_rvalid_o
//
// Build option: define DMEM_RESP_ERR_EN to answer addresses outside the
// mapped window with data_err_o=1 (and no write). Without it data_err_o is 0
// and the word index simply wraps modulo MEM_WORDS.

module dmem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Last counter value before the grant; irrelevant when WAIT_STATES == 0.
  localparam int          WS_LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WS_LAST   = WS_LAST_I[3:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q;
  logic [3:0]    wait_cnt_q;

  // Response bookkeeping captured in the grant cycle.
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [MEM_WORDS];

  logic          gnt;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          access_ok;

  // BASE_ADDR is aligned to the window size, so the word index is just the
  // address bits above the byte offset; out-of-window addresses alias.
  assign word_idx = data_addr_i[AW+1:2];

`ifdef DMEM_RESP_ERR_EN
  // Window check by comparing the bits above the window against the base.
  assign in_range  = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign access_ok = in_range;

  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];
`else
  assign in_range  = 1'b1;
  assign access_ok = 1'b1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0], BASE_ADDR};
`endif

  // Grant is combinational: same-cycle in IDLE with no wait states, or on the
  // final wait cycle. Reset masks it regardless of the request.
  always_comb begin
    gnt = 1'b0;
    if (!rst_i && data_req_i) begin
      if (state_q == S_IDLE && WAIT_STATES == 0) begin
        gnt = 1'b1;
      end else if (state_q == S_WAIT && wait_cnt_q == WS_LAST) begin
        gnt = 1'b1;
      end
    end
  end

  assign data_gnt_o = gnt;

  // FSM and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_req_i) begin
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q    <= S_WAIT;
              wait_cnt_q <= 4'd0;
            end
          end
        end
        S_WAIT: begin
          if (!data_req_i) begin
            // Request withdrawn before grant: abandon silently.
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
          end else if (wait_cnt_q == WS_LAST) begin
            state_q <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          wait_cnt_q <= 4'd0;
        end
        default: begin
          state_q    <= S_IDLE;
          wait_cnt_q <= 4'd0;
        end
      endcase

      if (gnt) begin
        err_q <= !in_range;
        // Only a successful read carries data; writes and errors answer zero.
        if (!data_we_i && access_ok) begin
          rdata_q <= mem[word_idx];
        end else begin
          rdata_q <= 32'd0;
        end
      end
    end
  end

  // Memory array: no reset, contents survive rst_i. Writes commit on the
  // grant edge, so a read granted later sees the new value.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && access_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response outputs are gated by rst_i so a reset in the RESP cycle kills
  // the pulse in that same cycle.
  assign data_rvalid_o = (state_q == S_RESP) && !rst_i;
  assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'd0;

`ifdef DMEM_RESP_ERR_EN
  assign data_err_o = data_rvalid_o && err_q;
`else
  assign data_err_o = 1'b0;

  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req3;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        gnt0, rvalid0, err0;
  logic [31:0] rdata0;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata0), .data_err_o(err0)
  );

  dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req3), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata3), .data_err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the zero-wait instance; checks gnt and the response.
  task automatic xact0(input string tag, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err);
    req0 = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    check({tag, "_gnt"}, {31'd0, gnt0}, 32'd1);
    check({tag, "_rv_early"}, {31'd0, rvalid0}, 32'd0);
    tick();
    req0 = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    #1;
    check({tag, "_rvalid"}, {31'd0, rvalid0}, 32'd1);
    check({tag, "_gnt_resp"}, {31'd0, gnt0}, 32'd0);
    check({tag, "_rdata"}, rdata0, exp_rdata);
    check({tag, "_err"}, {31'd0, err0}, {31'd0, exp_err});
    tick();
    check({tag, "_rv_off"}, {31'd0, rvalid0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req3 = 1'b1; we = 1'b0; be = 4'h0;
    addr = 32'h0010_0000; wdata = 32'h0;

    // Reset: grant masked even with request high, all outputs zero.
    tick(); tick();
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_gnt3", {31'd0, gnt3}, 32'd0);
    check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    req0 = 1'b0; req3 = 1'b0;
    rst = 1'b0;
    tick();

    // Full write then read back.
    xact0("wr_full", 1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact0("rd_full", 1'b0, 4'h0, 32'h0010_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Partial write, bytes 0 and 2: DE AD BE EF -> DE 22 BE 44.
    xact0("wr_part", 1'b1, 4'b0101, 32'h0010_0010, 32'h1122_3344, 32'h0, 1'b0);
    xact0("rd_part", 1'b0, 4'h0, 32'h0010_0010, 32'h0, 32'hDE22_BE44, 1'b0);

    // be=0 writes nothing but still responds; low address bits ignored.
    xact0("wr_be0", 1'b1, 4'h0, 32'h0010_0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xact0("rd_lowbits", 1'b0, 4'hF, 32'h0010_0013, 32'h0, 32'hDE22_BE44, 1'b0);

    // Word 0 known, then the out-of-window write.
    xact0("wr_w0", 1'b1, 4'hF, 32'h0010_0000, 32'h1234_5678, 32'h0, 1'b0);
`ifdef DMEM_RESP_ERR_EN
    xact0("wr_oob", 1'b1, 4'hF, 32'h0010_1000, 32'hCAFE_F00D, 32'h0, 1'b1);
    xact0("rd_w0_after_oob", 1'b0, 4'h0, 32'h0010_0000, 32'h0, 32'h1234_5678, 1'b0);
    xact0("rd_oob", 1'b0, 4'h0, 32'h0010_1010, 32'h0, 32'h0, 1'b1);
`else
    xact0("wr_oob", 1'b1, 4'hF, 32'h0010_1000, 32'hCAFE_F00D, 32'h0, 1'b0);
    xact0("rd_w0_alias", 1'b0, 4'h0, 32'h0010_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif

    // Reset during the RESP cycle of a read.
    req0 = 1'b1; we = 1'b0; addr = 32'h0010_0010;
    #1;
    check("rstresp_gnt", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0; rst = 1'b1;
    #1;
    check("rstresp_rvalid", {31'd0, rvalid0}, 32'd0);
    check("rstresp_rdata", rdata0, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstresp_after_rv", {31'd0, rvalid0}, 32'd0);
    check("rstresp_after_rd", rdata0, 32'd0);
    check("rstresp_after_gnt", {31'd0, gnt0}, 32'd0);
    tick();
    xact0("rd_after_rst", 1'b0, 4'h0, 32'h0010_0010, 32'h0, 32'hDE22_BE44, 1'b0);

    // Three wait states: req from cycle 0, grant in cycle 3, rvalid in cycle 4.
    req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0010_0020; wdata = 32'hA5A5_A5A5;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("ws3_nogrant_c%0d", c), {31'd0, gnt3}, 32'd0);
      check($sformatf("ws3_norv_c%0d", c), {31'd0, rvalid3}, 32'd0);
      tick();
    end
    #1;
    check("ws3_gnt_c3", {31'd0, gnt3}, 32'd1);
    tick();
    req3 = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF;
    #1;
    check("ws3_rvalid_c4", {31'd0, rvalid3}, 32'd1);
    check("ws3_gnt_c4", {31'd0, gnt3}, 32'd0);
    tick();

    // Request withdrawn in cycle 1: no grant, no response.
    req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0010_0020; wdata = 32'h0BAD_0BAD;
    tick();
    req3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("drop_gnt_%0d", c), {31'd0, gnt3}, 32'd0);
      check($sformatf("drop_rv_%0d", c), {31'd0, rvalid3}, 32'd0);
      tick();
    end

    // Fresh read must again take exactly three cycles (FSM back in IDLE).
    req3 = 1'b1; we = 1'b0; addr = 32'h0010_0020;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("ws3rd_nogrant_c%0d", c), {31'd0, gnt3}, 32'd0);
      tick();
    end
    #1;
    check("ws3rd_gnt", {31'd0, gnt3}, 32'd1);
    tick();
    req3 = 1'b0;
    #1;
    check("ws3rd_rvalid", {31'd0, rvalid3}, 32'd1);
    check("ws3rd_rdata", rdata3, 32'hA5A5_A5A5);
    check("ws3rd_err", {31'd0, err3}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
